// File: rtl/spi_xfer_arbiter.sv
// Two-requester SPI transaction controller: round-robin grant, chip-select
// setup/hold bracketing, one engine handshake per word, with abort on timeout.
module spi_xfer_arbiter #(
  parameter int W_CPU    = 32,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_rd,
  input  logic [2*W_CPU-1:0] req_data,
  output logic [1:0]         rsp_valid,
  output logic [W_CPU-1:0]   rsp_data,
  output logic               rsp_timeout,
  input  logic               eng_tx_ready,
  output logic               eng_tx_start,
  output logic [W_CPU-1:0]   eng_tx_data,
  output logic               eng_rx_start,
  input  logic               eng_rx_valid,
  input  logic [W_CPU-1:0]   eng_rx_data,
  output logic               spi_cs_n,
  output logic               busy,
  output logic               owner
);

  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int PMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, WAIT, HOLD, DONE} state_t;

  state_t           state, nstate;
  logic             ptr, winner, accept, launch;
  logic             rd_q, abort_q, seen_low;
  logic             done_rd, cmpl, tmo;
  logic [TW-1:0]    tcnt;
  logic [PW-1:0]    pcnt;
  logic [W_CPU-1:0] rx_q;

  always_comb begin
    winner    = req_valid[ptr] ? ptr : ~ptr;
    req_ready = '0;
    if (rst && state == IDLE && |req_valid) req_ready[winner] = 1'b1;
    accept    = |(req_valid & req_ready);
  end

  // A write is done once the engine has visibly gone busy and come back idle.
  assign done_rd = (state == WAIT) && rd_q && eng_rx_valid;
  assign cmpl    = done_rd || ((state == WAIT) && !rd_q && seen_low && eng_tx_ready);
  assign tmo     = (state == LAUNCH || state == WAIT) && (tcnt == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  // launch registers the start pulse so it lands in the first LAUNCH cycle
  always_comb begin
    nstate = state;
    launch = 1'b0;
    case (state)
      IDLE:   if (accept) nstate = SETUP;
      SETUP:  if (pcnt == PW'(CS_SETUP - 1)) begin
                nstate = LAUNCH;
                launch = eng_tx_ready;
              end
      LAUNCH: if (tmo)               nstate = HOLD;
              else if (eng_tx_start) nstate = WAIT;
              else                   launch = eng_tx_ready;
      WAIT:   if (cmpl || tmo) nstate = HOLD;
      HOLD:   if (pcnt == PW'(CS_HOLD - 1)) nstate = DONE;
      DONE:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= 1'b0;
      owner        <= 1'b0;
      rd_q         <= 1'b0;
      abort_q      <= 1'b0;
      seen_low     <= 1'b0;
      rx_q         <= '0;
      tcnt         <= '0;
      pcnt         <= '0;
      eng_tx_data  <= '0;
      eng_tx_start <= 1'b0;
      eng_rx_start <= 1'b0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      spi_cs_n     <= 1'b1;
      busy         <= 1'b0;
    end else begin
      if (accept) begin
        owner       <= winner;
        ptr         <= ~winner;
        rd_q        <= req_rd[winner];
        eng_tx_data <= winner ? req_data[2*W_CPU-1:W_CPU] : req_data[W_CPU-1:0];
        rx_q        <= '0;
        abort_q     <= 1'b0;
      end
      if (done_rd)      rx_q    <= eng_rx_data;
      if (tmo && !cmpl) abort_q <= 1'b1;

      pcnt     <= (nstate == state && (state == SETUP || state == HOLD)) ? pcnt + 1'b1 : '0;
      tcnt     <= (state == LAUNCH || state == WAIT) ? tcnt + 1'b1 : '0;
      seen_low <= (state == WAIT) ? (seen_low | ~eng_tx_ready) : 1'b0;

      eng_tx_start <= launch;
      eng_rx_start <= launch & rd_q;
      spi_cs_n     <= (nstate == IDLE || nstate == DONE);
      busy         <= (nstate != IDLE);

      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      if (nstate == DONE) begin
        rsp_valid[owner] <= 1'b1;
        rsp_data         <= rx_q;
        rsp_timeout      <= abort_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter: a default instance and a short-timeout
// instance share stimulus; sel picks which one the engine model and monitor follow.
module tb_spi_xfer_arbiter;

  logic        clk, rst, sel;
  logic [1:0]  req_valid, req_rd;
  logic [63:0] req_data;
  logic        eng_tx_ready, eng_rx_valid;
  logic [31:0] eng_rx_data;

  logic [1:0]  a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
  logic [31:0] a_rsp_data, b_rsp_data, a_tx_data, b_tx_data;
  logic        a_rsp_tmo, b_rsp_tmo, a_tx_start, b_tx_start, a_rx_start, b_rx_start;
  logic        a_cs_n, b_cs_n, a_busy, b_busy, a_owner, b_owner;

  logic [1:0]  o_req_ready, o_rsp_valid;
  logic [31:0] o_rsp_data, o_tx_data;
  logic        o_rsp_tmo, o_tx_start, o_rx_start, o_cs_n, o_busy, o_owner;

  spi_xfer_arbiter u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_rd(req_rd), .req_data(req_data), .rsp_valid(a_rsp_valid),
    .rsp_data(a_rsp_data), .rsp_timeout(a_rsp_tmo), .eng_tx_ready(eng_tx_ready),
    .eng_tx_start(a_tx_start), .eng_tx_data(a_tx_data), .eng_rx_start(a_rx_start),
    .eng_rx_valid(eng_rx_valid), .eng_rx_data(eng_rx_data), .spi_cs_n(a_cs_n),
    .busy(a_busy), .owner(a_owner));

  spi_xfer_arbiter #(.TIMEOUT(15)) u_dut_t (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_rd(req_rd), .req_data(req_data), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data), .rsp_timeout(b_rsp_tmo), .eng_tx_ready(eng_tx_ready),
    .eng_tx_start(b_tx_start), .eng_tx_data(b_tx_data), .eng_rx_start(b_rx_start),
    .eng_rx_valid(eng_rx_valid), .eng_rx_data(eng_rx_data), .spi_cs_n(b_cs_n),
    .busy(b_busy), .owner(b_owner));

  assign o_req_ready = sel ? b_req_ready : a_req_ready;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_rsp_data  = sel ? b_rsp_data  : a_rsp_data;
  assign o_rsp_tmo   = sel ? b_rsp_tmo   : a_rsp_tmo;
  assign o_tx_start  = sel ? b_tx_start  : a_tx_start;
  assign o_tx_data   = sel ? b_tx_data   : a_tx_data;
  assign o_rx_start  = sel ? b_rx_start  : a_rx_start;
  assign o_cs_n      = sel ? b_cs_n      : a_cs_n;
  assign o_busy      = sel ? b_busy      : a_busy;
  assign o_owner     = sel ? b_owner     : a_owner;

  typedef struct { int idx; logic [31:0] data; logic tmo; } exp_t;
  exp_t exp_q[$];
  int   grant_log[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_start = 0, n_rsp = 0, start_cyc = 0, rsp_cyc = 0, ready_up_cyc = 0;
  logic [31:0] start_data;
  logic        start_rx;

  int          eng_len = 32, eng_rx_dly = 100;
  bit          eng_stuck = 0;
  logic [31:0] eng_rx_word = 32'h0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: drops ready the cycle after start, returns it eng_len cycles later,
  // and pulses rx_valid eng_rx_dly cycles after start (reads and writes alike).
  initial begin
    int k;
    k = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        k = -1; eng_tx_ready = !eng_stuck; eng_rx_valid = 0;
      end else begin
        eng_rx_valid = 0;
        if (k >= 0) begin
          k++;
          if (k == 1) eng_tx_ready = 0;
          if (k == eng_rx_dly) begin eng_rx_valid = 1; eng_rx_data = eng_rx_word; end
          if (k == eng_len + 1) begin eng_tx_ready = 1; ready_up_cyc = cyc; k = -1; end
        end else if (eng_stuck) eng_tx_ready = 0;
        else if (o_tx_start) k = 0;
      end
    end
  end

  // Monitor: logs grants and starts, pops the scoreboard on every response.
  initial begin
    exp_t e;
    logic [1:0] ev;
    forever begin
      @(negedge clk); #1;
      if (|(req_valid & o_req_ready)) grant_log.push_back(o_req_ready[1] ? 1 : 0);
      if (o_tx_start) begin
        n_start++; start_cyc = cyc; start_data = o_tx_data; start_rx = o_rx_start;
      end
      if (o_rsp_valid != 2'b00) begin
        n_rsp++; rsp_cyc = cyc; n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b, expected none", o_rsp_valid);
        end else begin
          e  = exp_q.pop_front();
          ev = (e.idx == 1) ? 2'b10 : 2'b01;
          if (o_rsp_valid !== ev || o_rsp_data !== e.data || o_rsp_tmo !== e.tmo ||
              o_cs_n !== 1'b1 || o_owner !== ev[1]) begin
            n_fail++;
            $display("FAIL rsp: got valid=%b data=%h tmo=%b cs_n=%b owner=%b, expected valid=%b data=%h tmo=%b cs_n=1 owner=%b",
                     o_rsp_valid, o_rsp_data, o_rsp_tmo, o_cs_n, o_owner, ev, e.data, e.tmo, ev[1]);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 0; req_valid = 0; req_rd = 0; req_data = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    exp_q.delete(); grant_log.delete(); n_start = 0;
  endtask

  task automatic issue(input int idx, input bit rd, input logic [31:0] data, output int acc);
    @(negedge clk);
    req_valid[idx] = 1; req_rd[idx] = rd; req_data[idx*32 +: 32] = data;
    acc = -1;
    for (int t = 0; t < 200; t++) begin
      #1;
      if (o_req_ready[idx]) begin acc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid[idx] = 0;
    if (acc < 0) begin n_chk++; n_fail++; $display("FAIL grant_wait: got no grant, expected req%0d granted", idx); end
  endtask

  task automatic wait_done(input int budget, input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin @(negedge clk); t++; end
    #2;
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got %0d pending responses, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL %s: got %h, expected %h", name, got, exp); end
  endtask

  task automatic test_reset();
    sel = 0;
    @(negedge clk);
    rst = 0; req_valid = 2'b11; #1;
    if (o_req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b, expected 00", o_req_ready); end
    n_chk++;
    chk("rst_rsp_valid", {30'd0, o_rsp_valid}, 0);
    chk("rst_rsp_data", o_rsp_data, 0);
    chk("rst_rsp_tmo", {31'd0, o_rsp_tmo}, 0);
    chk("rst_starts", {30'd0, o_tx_start, o_rx_start}, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_cs_n", {31'd0, o_cs_n}, 1);
    chk("rst_busy_owner", {30'd0, o_busy, o_owner}, 0);
    req_valid = 0;
    do_reset();
  endtask

  task automatic test_single_write();
    int acc;
    sel = 0; eng_stuck = 0; eng_len = 32; eng_rx_dly = 5; eng_rx_word = 32'hFFFF_0000;
    do_reset();
    exp_q.push_back('{0, 32'h0, 1'b0});
    issue(0, 0, 32'hA5A5_0001, acc);
    wait_done(200, "write");
    chk("wr_start_count", n_start, 1);
    chk("wr_start_cycle", start_cyc - acc, 3);
    chk("wr_tx_data", start_data, 32'hA5A5_0001);
    chk("wr_rx_start", {31'd0, start_rx}, 0);
    chk("wr_rsp_after_ready", rsp_cyc - ready_up_cyc, 3);
  endtask

  task automatic test_read();
    int acc;
    sel = 0; eng_stuck = 0; eng_len = 32; eng_rx_dly = 10; eng_rx_word = 32'hDEAD_BEEF;
    do_reset();
    exp_q.push_back('{1, 32'hDEAD_BEEF, 1'b0});
    issue(1, 1, 32'h1234_5678, acc);
    wait_done(200, "read");
    chk("rd_rx_start", {31'd0, start_rx}, 1);
    chk("rd_start_cycle", start_cyc - acc, 3);
    chk("rd_tx_data", start_data, 32'h1234_5678);
    chk("rd_rsp_cycle", rsp_cyc - start_cyc, 13);
  endtask

  task automatic test_contention();
    int t;
    sel = 0; eng_stuck = 0; eng_len = 4; eng_rx_dly = 2; eng_rx_word = 32'hC0DE_0001;
    do_reset();
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{i % 2, (i % 2) ? 32'hC0DE_0001 : 32'h0, 1'b0});
    @(negedge clk);
    req_data = {32'h2222_0002, 32'h1111_0001}; req_rd = 2'b10; req_valid = 2'b11;
    for (t = 0; t < 400 && grant_log.size() < 4; t++) begin @(negedge clk); #2; end
    @(negedge clk);
    req_valid = 0;
    chk("cont_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("cont_grant_order", grant_log[i], i % 2);
    wait_done(200, "contention");
  endtask

  task automatic test_timeout();
    int acc;
    sel = 1; eng_stuck = 1; eng_len = 32; eng_rx_dly = 100;
    do_reset();
    exp_q.push_back('{0, 32'h0, 1'b1});
    issue(0, 0, 32'h7777_0000, acc);
    wait_done(100, "tmo");
    chk("tmo_no_start", n_start, 0);
    chk("tmo_rsp_cycle", rsp_cyc - acc, 21);
    chk("tmo_cs_released", {30'd0, o_cs_n, o_busy}, 32'd2);
    eng_stuck = 0;
  endtask

  task automatic test_reset_mid_wait();
    int acc, r0, t;
    sel = 0; eng_stuck = 0; eng_len = 32; eng_rx_dly = 100;
    do_reset();
    issue(0, 0, 32'h0BAD_0001, acc);
    repeat (6) @(negedge clk);
    #1;
    chk("mid_pre_busy", {30'd0, o_cs_n, o_busy}, 32'd1);
    #1; rst = 0; #1;
    chk("mid_async_cs_busy", {30'd0, o_cs_n, o_busy}, 32'd2);
    r0 = n_rsp;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (4) @(negedge clk);
    chk("mid_no_rsp", n_rsp - r0, 0);
    grant_log.delete();
    exp_q.push_back('{0, 32'h0, 1'b0});
    req_rd = 0; req_valid = 2'b11;
    for (t = 0; t < 50 && grant_log.size() < 1; t++) begin @(negedge clk); #2; end
    @(negedge clk);
    req_valid = 0;
    chk("mid_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    wait_done(200, "mid");
  endtask

  task automatic test_simultaneous();
    int acc;
    sel = 1; eng_stuck = 0; eng_len = 32; eng_rx_dly = 15; eng_rx_word = 32'h5EED_0015;
    do_reset();
    exp_q.push_back('{0, 32'h5EED_0015, 1'b0});
    issue(0, 1, 32'h0, acc);
    wait_done(100, "simul");
    eng_rx_dly = 16;
    do_reset();
    exp_q.push_back('{0, 32'h0, 1'b1});
    issue(0, 1, 32'h0, acc);
    wait_done(100, "late_rx");
  endtask

  initial begin
    rst = 0; sel = 0; req_valid = 0; req_rd = 0; req_data = 0;
    eng_tx_ready = 1; eng_rx_valid = 0; eng_rx_data = 0;
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_timeout();
    test_reset_mid_wait();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Transaction controller that shares the SPI MOSI/MISO shift engines between two requesters, typically the CPU coprocessor-register port and a second master. It arbitrates round-robin and brackets each word with chip-select setup/hold. It sequences one engine start/complete handshake per transaction, with timeout, and returns a one-cycle response to the granted requester. It sits between the requesters and the MOSI/MISO engines and owns `spi_cs_n`.

## Interface
- `W_CPU`, 32: data word width
- `CS_SETUP`, 2: cycles `spi_cs_n` is low before engine launch (legal range is 1 and up)
- `CS_HOLD`, 2: cycles `spi_cs_n` stays low after completion (legal range is 1 and up)
- `TIMEOUT`, 1023: cycles allowed in LAUNCH+WAIT before abort; counter width is `$clog2(TIMEOUT+1)`

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  2  per-requester transaction request
- `req_ready`  out  2  grant/accept, one-hot; a transfer is accepted on `req_valid[i] & req_ready[i]`
- `req_rd`  in  2  per requester: 1 = read (capture MISO word), 0 = write only
- `req_data`  in  2*W_CPU  TX words; requester i uses bits `[i*W_CPU +: W_CPU]`
- `rsp_valid`  out  2  one-cycle completion pulse to the owner
- `rsp_data`  out  W_CPU  received word; 0 for writes and timeouts
- `rsp_timeout`  out  1  qualifies `rsp_valid`: 1 means the transaction was aborted
- `eng_tx_ready`  in  1  MOSI engine idle
- `eng_tx_start`  out  1  one-cycle launch pulse
- `eng_tx_data`  out  W_CPU  latched TX word
- `eng_rx_start`  out  1  one-cycle MISO capture arm (reads only)
- `eng_rx_valid`  in  1  MISO word-complete pulse
- `eng_rx_data`  in  W_CPU  received word
- `spi_cs_n`  out  1  active-low chip select
- `busy`  out  1  state is not IDLE
- `owner`  out  1  index of the current or last granted requester

## Operation
- States: IDLE, SETUP, LAUNCH, WAIT, HOLD, DONE.
- **IDLE:** the winner is the lowest index at or after the priority pointer with `req_valid` high. `req_ready[winner]`=1 combinationally. On accept:
  - latch `req_data` slice, `req_rd`, and `owner`
  - set the pointer to `owner+1` (mod 2)
  - go to SETUP
- **SETUP:** `spi_cs_n`=0; count `CS_SETUP` cycles, then go to LAUNCH.
- **LAUNCH:** when `eng_tx_ready`=1:
  - pulse `eng_tx_start` with `eng_tx_data` driven
  - if rd, pulse `eng_rx_start` in the same cycle
  - go to WAIT
- **WAIT:**
  - Write completes on the first cycle `eng_tx_ready`=1 after it has been sampled 0.
  - Read completes on `eng_rx_valid`=1, capturing `eng_rx_data`.
  - `eng_rx_valid` during a write is ignored.
- **Timeout:** a counter clears on entry to LAUNCH and increments each LAUNCH/WAIT cycle. At `TIMEOUT` without completion, set the abort flag and go to HOLD.
- **HOLD:** `spi_cs_n`=0 for `CS_HOLD` cycles, then go to DONE.
- **DONE:** for one cycle:
  - `spi_cs_n`=1
  - `rsp_valid[owner]`=1
  - drive `rsp_data` and `rsp_timeout`
  - then go to IDLE
- Any `req_valid` outside IDLE is held off (`req_ready`=0). A request withdrawn before grant has no effect.
- Completion and timeout in the same cycle: completion wins, `rsp_timeout`=0.

## Timing
- Reset (`rst`=0, asynchronous) values:
  - state IDLE, pointer 0, `owner` 0
  - `req_ready` gated to 0 while `rst`=0
  - `rsp_valid`=0, `rsp_data`=0, `rsp_timeout`=0
  - `eng_tx_start`=0, `eng_rx_start`=0, `eng_tx_data`=0
  - `spi_cs_n`=1, `busy`=0
- Reset mid-transaction: the same values apply immediately; no `rsp_valid` is issued for the aborted transaction.
- Accept at edge of cycle 0; `spi_cs_n` falls in cycle 1; launch no earlier than cycle `CS_SETUP+1`.
- If completion is sampled in cycle Tc: HOLD occupies Tc+1 to Tc+CS_HOLD, DONE is Tc+CS_HOLD+1, and the next grant is possible at Tc+CS_HOLD+2.
- Minimum back-to-back spacing: `spi_cs_n` is high for at least one cycle (the DONE cycle) between transactions.
- All outputs except `req_ready` are registered.

## Test plan
- **Single write:** req0 with data 0xA5A5_0001, engine drops ready 1 cycle after start and raises it 32 cycles later. Expect:
  - exactly one `eng_tx_start` pulse, in cycle 3
  - `eng_tx_data`=0xA5A5_0001
  - `rsp_valid[0]` 3 cycles after ready returns
  - `rsp_data`=0, `rsp_timeout`=0
- **Read:** req1 with rd=1, engine returns `eng_rx_valid` with 0xDEAD_BEEF. Expect:
  - `eng_rx_start` coincident with `eng_tx_start`
  - `rsp_valid[1]` with `rsp_data`=0xDEAD_BEEF
- **Contention:** both requesters held valid for 4 transactions. Expect grants in order 0,1,0,1 and `spi_cs_n` high for at least one cycle between each.
- **Timeout:** `eng_tx_ready` stuck at 0 with `TIMEOUT`=15. Expect:
  - no start pulse
  - `rsp_valid` with `rsp_timeout`=1, `rsp_data`=0
  - `spi_cs_n` returns to 1
- **Reset mid-WAIT:** assert `rst`=0 during WAIT. Expect:
  - `spi_cs_n`=1 and `busy`=0 without waiting for a clock edge
  - no `rsp_valid`
  - the next request is granted to requester 0 first
- **Simultaneous completion and timeout:** `eng_rx_valid` arrives exactly at count `TIMEOUT`. Expect `rsp_timeout`=0 and the received data returned.
